// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access
//  Description : MEM-stage load/store unit. Accepts one instruction at a time,
//                issues an aligned word request on the data bus with lane
//                mask/data, aligns and extends load results, and reports
//                misaligned-address and response-timeout faults.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_access #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_addr,
    input  logic [7:0]  in_mem_type,
    input  logic [31:0] in_wdata,
    output logic        dbus_req,
    output logic        dbus_wen,
    output logic [31:0] dbus_addr,
    output logic [3:0]  dbus_wmask,
    output logic [31:0] dbus_wdata,
    input  logic        dbus_gnt,
    input  logic        dbus_rvalid,
    input  logic [31:0] dbus_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_load_data,
    output logic        out_misalign,
    output logic        out_bus_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Last WAIT count value; reaching it without a response ends the access.
    localparam logic [7:0] c_TO_LAST = 8'(TIMEOUT_CYC - 1);

    state_t      r_state;
    logic [31:0] r_addr;
    logic [7:0]  r_type;
    logic [31:0] r_wdata;
    logic [7:0]  r_cnt;
    logic [31:0] r_load_data;
    logic        r_misalign;
    logic        r_bus_err;

    logic        w_accept;
    logic        w_is_mem;
    logic        w_misalign;
    logic        w_is_store;
    logic [31:0] w_rshift;
    logic [31:0] w_load_data;
    logic [3:0]  w_wmask;
    logic [31:0] w_wdata;

    assign w_accept   = in_valid && in_ready;
    assign w_is_mem   = |in_mem_type;
    // Halfwords need even addresses, words need 4-byte alignment.
    assign w_misalign = ((in_mem_type[1] | in_mem_type[4] | in_mem_type[6]) & in_addr[0])
                      | ((in_mem_type[2] | in_mem_type[7]) & (in_addr[1:0] != 2'b00));
    assign w_is_store = |r_type[7:5];
    assign w_rshift   = dbus_rdata >> {r_addr[1:0], 3'b000};

    // Extract and extend the addressed byte/halfword from the response word.
    always_comb begin
        w_load_data = 32'h0;
        if (r_type[0])      w_load_data = {{24{w_rshift[7]}}, w_rshift[7:0]};
        else if (r_type[1]) w_load_data = {{16{w_rshift[15]}}, w_rshift[15:0]};
        else if (r_type[2]) w_load_data = w_rshift;
        else if (r_type[3]) w_load_data = {24'h0, w_rshift[7:0]};
        else if (r_type[4]) w_load_data = {16'h0, w_rshift[15:0]};
    end

    // Place store data into its byte lanes; loads write no lanes.
    always_comb begin
        w_wmask = 4'b0000;
        w_wdata = 32'h0;
        if (r_type[5]) begin
            w_wmask = 4'b0001 << r_addr[1:0];
            w_wdata = {4{r_wdata[7:0]}};
        end else if (r_type[6]) begin
            w_wmask = 4'b0011 << r_addr[1:0];
            w_wdata = {2{r_wdata[15:0]}};
        end else if (r_type[7]) begin
            w_wmask = 4'b1111;
            w_wdata = r_wdata;
        end
    end

    // Access sequencing: accept, request, wait for response or timeout, hand off.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_addr      <= 32'h0;
            r_type      <= 8'h0;
            r_wdata     <= 32'h0;
            r_cnt       <= 8'h0;
            r_load_data <= 32'h0;
            r_misalign  <= 1'b0;
            r_bus_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        r_addr      <= in_addr;
                        r_type      <= in_mem_type;
                        r_wdata     <= in_wdata;
                        r_cnt       <= 8'h0;
                        r_load_data <= 32'h0;
                        r_bus_err   <= 1'b0;
                        r_misalign  <= w_misalign;
                        r_state     <= (!w_is_mem || w_misalign) ? S_DONE : S_REQ;
                    end else if (r_state == S_DONE && out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                S_REQ: begin
                    // A response in the grant cycle belongs to no accepted request.
                    if (dbus_gnt) begin
                        r_cnt   <= 8'h0;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (dbus_rvalid) begin
                        r_load_data <= w_is_store ? 32'h0 : w_load_data;
                        r_state     <= S_DONE;
                    end else if (r_cnt == c_TO_LAST) begin
                        r_bus_err   <= 1'b1;
                        r_load_data <= 32'h0;
                        r_state     <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Handshake and result outputs are forced inactive while reset is held.
    assign in_ready      = rst && ((r_state == S_IDLE) || ((r_state == S_DONE) && out_ready));
    assign dbus_req      = rst && (r_state == S_REQ);
    assign out_valid     = rst && (r_state == S_DONE);
    assign out_load_data = rst ? r_load_data : 32'h0;
    assign out_misalign  = rst && r_misalign;
    assign out_bus_err   = rst && r_bus_err;

    assign dbus_wen      = w_is_store;
    assign dbus_addr     = {r_addr[31:2], 2'b00};
    assign dbus_wmask    = w_wmask;
    assign dbus_wdata    = w_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access
//  Description : Scoreboard bench for mem_access with a behavioural data-bus
//                responder and a write-back sink.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_access;

    localparam logic [7:0] c_LB  = 8'h01, c_LH  = 8'h02, c_LW = 8'h04, c_LBU = 8'h08;
    localparam logic [7:0] c_LHU = 8'h10, c_SB  = 8'h20, c_SH = 8'h40, c_SW  = 8'h80;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_addr = 32'h0;
    logic [7:0]  in_mem_type = 8'h0;
    logic [31:0] in_wdata = 32'h0;
    logic        dbus_req, dbus_wen;
    logic [31:0] dbus_addr, dbus_wdata;
    logic [3:0]  dbus_wmask;
    logic        dbus_gnt = 1'b0;
    logic        dbus_rvalid = 1'b0;
    logic [31:0] dbus_rdata = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_load_data;
    logic        out_misalign, out_bus_err;

    mem_access #(.TIMEOUT_CYC(4)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
        .in_mem_type(in_mem_type), .in_wdata(in_wdata),
        .dbus_req(dbus_req), .dbus_wen(dbus_wen), .dbus_addr(dbus_addr),
        .dbus_wmask(dbus_wmask), .dbus_wdata(dbus_wdata),
        .dbus_gnt(dbus_gnt), .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_load_data(out_load_data),
        .out_misalign(out_misalign), .out_bus_err(out_bus_err)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Scoreboards: results {err, mis, data}; bus requests {wen, mask, addr, wdata}.
    logic [33:0] exp_q[$];
    logic [68:0] exp_bus[$];

    // Responder configuration, set by the stimulus before each access.
    int          gnt_dly = 0;
    int          rv_dly  = 1;
    bit          rv_en   = 1'b1;
    bit          to_mode = 1'b0;
    bit          chk_lat = 1'b1;
    bit          same_rv = 1'b0;
    logic [31:0] rd_cfg  = 32'h0;

    task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic misal_f(input logic [31:0] a, input logic [7:0] t);
        logic half, word;
        half = (t == c_LH) || (t == c_LHU) || (t == c_SH);
        word = (t == c_LW) || (t == c_SW);
        return (half && a[0]) || (word && (a[1:0] != 2'b00));
    endfunction

    function automatic logic [33:0] res_f(input logic [31:0] a, input logic [7:0] t,
                                          input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] d;
        b = rd[8*a[1:0] +: 8];
        h = a[1] ? rd[31:16] : rd[15:0];
        d = 32'h0;
        if (!misal_f(a, t)) begin
            case (t)
                c_LB:    d = {{24{b[7]}}, b};
                c_LBU:   d = {24'h0, b};
                c_LH:    d = {{16{h[15]}}, h};
                c_LHU:   d = {16'h0, h};
                c_LW:    d = rd;
                default: d = 32'h0;
            endcase
        end
        return {1'b0, misal_f(a, t), d};
    endfunction

    function automatic logic [68:0] bus_f(input logic [31:0] a, input logic [7:0] t,
                                          input logic [31:0] w);
        logic [3:0]  m;
        logic [31:0] d;
        m = 4'h0;
        d = 32'h0;
        case (t)
            c_SB:    begin m = 4'b0001 << a[1:0]; d = {4{w[7:0]}};  end
            c_SH:    begin m = a[1] ? 4'b1100 : 4'b0011; d = {2{w[15:0]}}; end
            c_SW:    begin m = 4'b1111; d = w; end
            default: begin m = 4'h0; d = 32'h0; end
        endcase
        return {(m != 4'h0), m, a[31:2], 2'b00, d};
    endfunction

    // Data-bus responder: checks each request, grants, then answers or stays silent.
    initial begin
        logic [68:0] eb;
        logic [68:0] held;
        forever begin
            @(negedge clk);
            if (dbus_req) begin
                eb = 69'h0;
                if (exp_bus.size() == 0) check_eq("unexp_req", 72'd1, 72'd0);
                else begin
                    eb = exp_bus.pop_front();
                    check_eq("bus_req", {dbus_wen, dbus_wmask, dbus_addr, eb[68] ? dbus_wdata : 32'h0}, eb);
                end
                held = {dbus_wen, dbus_wmask, dbus_addr, dbus_wdata};
                for (int i = 0; i < gnt_dly; i++) begin
                    @(negedge clk);
                    check_eq("req_hold", {dbus_req, dbus_wen, dbus_wmask, dbus_addr, dbus_wdata}, {1'b1, held});
                end
                dbus_gnt    = 1'b1;
                dbus_rvalid = same_rv;
                dbus_rdata  = 32'hDEAD_BEEF;
                @(negedge clk);
                dbus_gnt    = 1'b0;
                dbus_rvalid = 1'b0;
                if (rv_en) begin
                    for (int i = 1; i < rv_dly; i++) @(negedge clk);
                    dbus_rvalid = 1'b1;
                    dbus_rdata  = rd_cfg;
                    @(negedge clk);
                    dbus_rvalid = 1'b0;
                    if (chk_lat) check_eq("rv_to_ov", {71'h0, out_valid}, 72'd1);
                end else if (to_mode) begin
                    repeat (3) @(negedge clk);
                    check_eq("to_early", {71'h0, out_valid}, 72'd0);
                    @(negedge clk);
                    check_eq("to_lat", {71'h0, out_valid}, 72'd1);
                end
            end
        end
    end

    // Write-back sink: compare every handed-off result with the scoreboard.
    initial begin
        logic [33:0] e;
        forever begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check_eq("unexp_out", 72'd1, 72'd0);
                else begin
                    e = exp_q.pop_front();
                    check_eq("result", {out_bus_err, out_misalign, out_load_data}, e);
                    check_eq("fault_excl", {71'h0, out_bus_err & out_misalign}, 72'd0);
                end
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [7:0] t, input logic [31:0] w);
        bit ok;
        @(posedge clk); #1;
        in_valid = 1'b1; in_addr = a; in_mem_type = t; in_wdata = w;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
        end
        if (!ok) check_eq("accept_to", 72'd0, 72'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            check_eq("drain_to", 72'(exp_q.size()), 72'd0);
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic do_mem(input logic [31:0] a, input logic [7:0] t,
                          input logic [31:0] w, input logic [31:0] rd);
        rd_cfg = rd;
        if (t != 8'h0 && !misal_f(a, t)) exp_bus.push_back(bus_f(a, t, w));
        if (to_mode) exp_q.push_back({2'b10, 32'h0});
        else         exp_q.push_back(res_f(a, t, rd));
        send(a, t, w);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [34:0] snap;
        // Reset values, then readiness in the first cycle after release.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_outs", {66'h0, in_ready, out_valid, dbus_req, out_misalign, out_bus_err, |out_load_data}, 72'd0);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check_eq("rst_rdy", {71'h0, in_ready}, 72'd1);

        // Loads and stores across lanes, grant/response latencies.
        gnt_dly = 2; rv_dly = 2;
        do_mem(32'h103, c_LB,  32'h0,         32'h80FF_1234);
        gnt_dly = 0; rv_dly = 1;
        do_mem(32'h202, c_SH,  32'h0000_ABCD, 32'h1111_2222);
        do_mem(32'h101, c_LBU, 32'h0,         32'h1234_80AB);
        do_mem(32'h002, c_LHU, 32'h0,         32'h8765_4321);
        gnt_dly = 1; rv_dly = 3;
        do_mem(32'h000, c_LH,  32'h0,         32'h0000_F00D);
        do_mem(32'h012, c_LH,  32'h0,         32'h9ABC_0001);
        do_mem(32'h010, c_LW,  32'h0,         32'hCAFE_F00D);
        gnt_dly = 0; rv_dly = 1;
        do_mem(32'h003, c_SB,  32'h0000_005A, 32'h0);
        do_mem(32'h020, c_SW,  32'h1357_9BDF, 32'h0);
        // Response in the grant cycle must be ignored; the later one counts.
        same_rv = 1'b1; rv_dly = 2;
        do_mem(32'h102, c_LB,  32'h0,         32'h00C3_0000);
        same_rv = 1'b0; rv_dly = 1;

        // Response timeout.
        rv_en = 1'b0; to_mode = 1'b1;
        do_mem(32'h040, c_LW, 32'h0, 32'h0);
        rv_en = 1'b1; to_mode = 1'b0;
        check_eq("to_idle", {71'h0, in_ready}, 72'd1);

        // Misaligned result held while write-back stalls, then back-to-back flow.
        out_ready = 1'b0;
        exp_q.push_back(res_f(32'h6, c_LW, 32'h0));
        send(32'h6, c_LW, 32'hFFFF_FFFF);
        @(negedge clk);
        snap = {out_valid, out_misalign, out_bus_err, out_load_data};
        check_eq("mis_out", {37'h0, snap}, {37'h0, 1'b1, 1'b1, 1'b0, 32'h0});
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("stall_hold", {37'h0, out_valid, out_misalign, out_bus_err, out_load_data}, {37'h0, snap});
        end
        exp_q.push_back(res_f(32'h11, 8'h00, 32'h0));
        exp_q.push_back(res_f(32'h01, c_LH, 32'h0));
        exp_q.push_back(res_f(32'h22, 8'h00, 32'h0));
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_addr = (k == 0) ? 32'h11 : (k == 1) ? 32'h01 : 32'h22;
            in_mem_type = (k == 1) ? c_LH : 8'h00;
            @(negedge clk);
            check_eq("b2b_rdy", {70'h0, in_ready, out_valid}, 72'd3);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("b2b_last", {71'h0, out_valid}, 72'd1);
        drain();

        // Reset during WAIT; the late response must be ignored.
        chk_lat = 1'b0; rv_dly = 5;
        exp_bus.push_back(bus_f(32'h80, c_LW, 32'h0));
        rd_cfg = 32'h5555_AAAA;
        send(32'h80, c_LW, 32'h0);
        @(posedge clk);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_eq("midrst_outs", {66'h0, in_ready, out_valid, dbus_req, out_misalign, out_bus_err, |out_load_data}, 72'd0);
        @(posedge clk);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check_eq("midrst_rdy", {71'h0, in_ready}, 72'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("late_rv", {38'h0, out_valid, out_misalign, out_load_data}, 72'd0);
        end
        check_eq("bus_left", 72'(exp_bus.size()), 72'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Parameters
REQ-001 SHALL provide parameter TIMEOUT_CYC, default 255: the maximum number of cycles to wait for dbus_rvalid before aborting the access (range 1..255).

Interface
REQ-002 SHALL have port clk, input, 1 bit: the single clock. All state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-low reset (rst=0 at a clk edge resets the block).
REQ-004 SHALL have in_valid, input, 1 bit: the upstream MEM-stage register holds a valid instruction.
REQ-005 SHALL have in_ready, output, 1 bit: this block accepts the upstream instruction this cycle.
REQ-006 SHALL have in_addr, input, 32 bits: the byte address (the ALU result).
REQ-007 SHALL have in_mem_type, input, 8 bits: one-hot access type. Bits: 0 LB, 1 LH, 2 LW, 3 LBU, 4 LHU, 5 SB, 6 SH, 7 SW. All zero means a non-memory instruction.
REQ-008 SHALL have in_wdata, input, 32 bits: the store data, unshifted.
REQ-009 SHALL have dbus_req, output, 1 bit: a data-bus request.
REQ-010 SHALL have dbus_wen, output, 1 bit: the request is a write.
REQ-011 SHALL have dbus_addr, output, 32 bits: the word-aligned address {in_addr[31:2],2'b00}.
REQ-012 SHALL have dbus_wmask, output, 4 bits: the byte-lane write mask.
REQ-013 SHALL have dbus_wdata, output, 32 bits: the store data shifted into its lanes.
REQ-014 SHALL have dbus_gnt, input, 1 bit: the bus accepts the request.
REQ-015 SHALL have dbus_rvalid, input, 1 bit: the response is valid. It is also returned for writes.
REQ-016 SHALL have dbus_rdata, input, 32 bits: the response word.
REQ-017 SHALL have out_valid, output, 1 bit: a result is available to the write-back stage.
REQ-018 SHALL have out_ready, input, 1 bit: the write-back stage accepts the result.
REQ-019 SHALL have out_load_data, output, 32 bits: the aligned and extended load result. It is 0 for stores, non-memory instructions and errors.
REQ-020 SHALL have out_misalign, output, 1 bit: an address-misaligned fault.
REQ-021 SHALL have out_bus_err, output, 1 bit: a response timeout fault.

Function
REQ-022 SHALL implement the states IDLE, REQ, WAIT and DONE.
REQ-023 in_ready SHALL be 1 when the state is IDLE, or when the state is DONE and out_ready=1. It SHALL be 0 otherwise.
REQ-024 On acceptance (in_valid && in_ready) SHALL register the address, type and wdata.
REQ-025 On acceptance of a non-memory or misaligned instruction SHALL go to DONE. out_valid is then 1 in the next cycle, and no dbus_req is issued.
REQ-026 Misalignment SHALL be: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0.
REQ-027 On acceptance of an aligned memory instruction SHALL go to REQ, with dbus_req=1 from the next cycle.
REQ-028 In REQ SHALL hold dbus_req and all dbus_* outputs stable until dbus_gnt=1, then go to WAIT. dbus_req SHALL be 0 in every other state.
REQ-029 In WAIT SHALL count cycles from 0. On dbus_rvalid SHALL capture the result and go to DONE.
REQ-030 In WAIT, if the count reaches TIMEOUT_CYC with no dbus_rvalid, SHALL go to DONE with out_bus_err=1 and out_load_data=0.
REQ-031 A dbus_rvalid arriving outside WAIT SHALL be ignored.
REQ-032 If dbus_gnt and dbus_rvalid are both 1 in the REQ cycle, SHALL still go to WAIT and capture only a later dbus_rvalid.
REQ-033 out_valid SHALL equal (state==DONE).
REQ-034 In DONE, the out_* outputs SHALL hold stable until out_ready=1.
REQ-035 On out_ready in DONE SHALL go to IDLE, or directly to REQ/DONE if a new instruction is accepted in the same cycle (back-to-back, no bubble).
REQ-036 Store lanes SHALL be: SB mask 4'b0001<<addr[1:0] with data {4{wdata[7:0]}}; SH mask 4'b0011<<addr[1:0] with data {2{wdata[15:0]}}; SW mask 4'b1111 with data wdata.
REQ-037 For loads, dbus_wmask SHALL be 0 and dbus_wen SHALL be 0.
REQ-038 Load extraction SHALL be: byte = rdata>>(8*addr[1:0]), half = rdata>>(8*addr[1:0]). LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
REQ-039 out_misalign and out_bus_err SHALL never both be 1.

Reset
REQ-040 While rst=0 at a clk edge SHALL go to IDLE and clear the timeout counter.
REQ-041 During reset SHALL drive dbus_req=0, out_valid=0, out_misalign=0, out_bus_err=0, out_load_data=0 and in_ready=0.
REQ-042 After rst returns to 1, in_ready SHALL be 1 in the first cycle.
REQ-043 A reset asserted in the middle of a transaction SHALL abandon the transaction. Responses to the abandoned transaction that arrive afterwards SHALL be ignored.

Verification
REQ-044 LB at addr 0x103, rdata 0x80FF_1234, gnt and rvalid each after 2 cycles -> out_load_data=0xFFFF_FF80, out_valid 1 cycle after rvalid.
REQ-045 SH wdata 0x0000_ABCD at addr 0x202 -> dbus_addr 0x200, wmask 4'b1100, wdata 0xABCD_ABCD, dbus_wen=1.
REQ-046 LW at addr 0x6 -> no dbus_req, out_misalign=1 and out_valid=1 in the next cycle, load_data=0.
REQ-047 LW with gnt but no rvalid, TIMEOUT_CYC=4 -> out_bus_err=1 after 4 WAIT cycles, state returns to IDLE on out_ready.
REQ-048 out_ready held low for 5 cycles, then back-to-back non-memory instructions -> outputs stable while stalled, then one result per cycle.
REQ-049 rst=0 in WAIT, then a late rvalid -> outputs stay at reset values and no out_valid is produced.
